// File: rtl/cnn_io_pkg.sv
// Shared types and sizing for the CNN / knapsack stream front end.
package cnn_io_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StWaitRes, StEmit} state_e;

  // Frame lengths in beats
  localparam logic [6:0] FrameLenCnn  = 7'd72;
  localparam logic [6:0] FrameLenKnap = 7'd36;

  // Buffer depths
  localparam logic [6:0] ImgDepth = 7'd72;
  localparam logic [4:0] KerDepth = 5'd18;
  localparam logic [5:0] WbDepth  = 6'd57;
  localparam logic [2:0] CapDepth = 3'd5;

  // Results expected back from the core per frame
  localparam logic [1:0] NumResCnn  = 2'd3;
  localparam logic [1:0] NumResKnap = 2'd1;

  function automatic logic [6:0] frame_len(input logic tsk);
    return tsk ? FrameLenKnap : FrameLenCnn;
  endfunction

  function automatic logic [1:0] num_res(input logic tsk);
    return tsk ? NumResKnap : NumResCnn;
  endfunction

endpackage

// File: rtl/cnn_stream_io_if.sv
// Input stream beats plus the result handshake toward the core.
interface cnn_stream_io_if;
  logic        in_valid;
  logic        task_number;
  logic [1:0]  mode;
  logic [31:0] Image;
  logic [31:0] Kernel_ch1;
  logic [31:0] Kernel_ch2;
  logic [31:0] Weight_Bias;
  logic [3:0]  capacity_cost;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        out_valid;
  logic [31:0] out;

  modport master (
    output in_valid, task_number, mode, Image, Kernel_ch1, Kernel_ch2, Weight_Bias,
           capacity_cost, res_valid, res_data,
    input  res_ready, out_valid, out
  );

  modport slave (
    input  in_valid, task_number, mode, Image, Kernel_ch1, Kernel_ch2, Weight_Bias,
           capacity_cost, res_valid, res_data,
    output res_ready, out_valid, out
  );
endinterface

// File: rtl/cnn_out_seq.sv
// Collects core results into rbuf and replays them as a registered output burst.
module cnn_out_seq
  import cnn_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wait_res,
  input  logic        emit,
  input  logic [1:0]  n_res,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        res_ready,
  output logic        last_accept,
  output logic        emit_done,
  output logic        out_valid,
  output logic [31:0] out
);

  logic [31:0] rbuf [3];
  logic [1:0]  acc_cnt_q;
  logic [1:0]  emit_idx_q;

  // Handshake and sequencing strobes for the top FSM
  always_comb begin
    res_ready   = wait_res && (acc_cnt_q < n_res);
    last_accept = res_valid && res_ready && (acc_cnt_q == n_res - 2'd1);
    emit_done   = emit && (emit_idx_q == n_res);
  end

  // Result capture; rbuf is not reset
  always_ff @(posedge clk) begin
    if (res_valid && res_ready) rbuf[acc_cnt_q] <= res_data;
  end

  // Accept counter and output burst; first word goes out on the last-accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q  <= '0;
      emit_idx_q <= '0;
      out_valid  <= 1'b0;
      out        <= '0;
    end else begin
      if (!wait_res) acc_cnt_q <= '0;
      else if (res_valid && res_ready) acc_cnt_q <= acc_cnt_q + 2'd1;

      if (last_accept) begin
        // With a single result rbuf[0] is being written this same edge
        out_valid  <= 1'b1;
        out        <= (acc_cnt_q == 2'd0) ? res_data : rbuf[0];
        emit_idx_q <= 2'd1;
      end else if (emit && (emit_idx_q < n_res)) begin
        out_valid  <= 1'b1;
        out        <= rbuf[emit_idx_q];
        emit_idx_q <= emit_idx_q + 2'd1;
      end else begin
        out_valid  <= 1'b0;
        out        <= '0;
        emit_idx_q <= '0;
      end
    end
  end

endmodule

// File: rtl/cnn_stream_io.sv
// Frame capture front end: buffers one input frame, then hands results back out.
module cnn_stream_io
  import cnn_io_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cnn_stream_io_if.slave    io,
  input  logic [6:0]        img_addr,
  output logic [31:0]       img_data,
  input  logic [4:0]        ker_addr,
  output logic [31:0]       ker1_data,
  output logic [31:0]       ker2_data,
  input  logic [5:0]        wb_addr,
  output logic [31:0]       wb_data,
  input  logic [2:0]        cap_addr,
  output logic [3:0]        cap_data,
  output logic              frame_ready,
  output logic              frame_task,
  output logic [1:0]        frame_mode,
  output logic              frame_err
);

  state_e      state_q, state_d;
  logic [6:0]  beat_cnt_q;
  logic        overrun_q;

  logic [31:0] img_mem  [ImgDepth];
  logic [31:0] ker1_mem [KerDepth];
  logic [31:0] ker2_mem [KerDepth];
  logic [31:0] wb_mem   [WbDepth];
  logic [3:0]  cap_mem  [CapDepth];

  logic        cur_task;
  logic [6:0]  cur_len;
  logic [6:0]  wr_idx;
  logic        wr_en, len_ok, err_pulse, ready_set;
  logic        last_accept, emit_done;

  // Beat 0 arrives in IDLE, before the header is latched
  assign cur_task = (state_q == StIdle) ? io.task_number : frame_task;
  assign cur_len  = frame_len(cur_task);
  assign len_ok   = (beat_cnt_q == cur_len) && !overrun_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (io.in_valid) state_d = StLoad;
      StLoad:    if (!io.in_valid) state_d = len_ok ? StWaitRes : StIdle;
      StWaitRes: if (last_accept) state_d = StEmit;
      StEmit:    if (emit_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    wr_idx    = (state_q == StIdle) ? 7'd0 : beat_cnt_q;
    wr_en     = io.in_valid &&
                ((state_q == StIdle) || ((state_q == StLoad) && (beat_cnt_q < cur_len)));
    ready_set = (state_q == StLoad) && !io.in_valid && len_ok;
    err_pulse = ((state_q == StLoad) && !io.in_valid && !len_ok) ||
                (((state_q == StWaitRes) || (state_q == StEmit)) && io.in_valid);
  end

  // Header latch, beat counter, overrun and frame status
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      frame_ready <= 1'b0;
      frame_task  <= 1'b0;
      frame_mode  <= '0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= err_pulse;
      if ((state_q == StIdle) && io.in_valid) begin
        frame_task <= io.task_number;
        frame_mode <= io.mode;
        beat_cnt_q <= 7'd1;
        overrun_q  <= 1'b0;
      end else if ((state_q == StLoad) && io.in_valid) begin
        if (beat_cnt_q != 7'h7f) beat_cnt_q <= beat_cnt_q + 7'd1;
        if (beat_cnt_q >= cur_len) overrun_q <= 1'b1;
      end
      if (ready_set)      frame_ready <= 1'b1;
      else if (emit_done) frame_ready <= 1'b0;
    end
  end

  // Buffer writes; buffers are never reset and keep stale entries
  always_ff @(posedge clk) begin
    if (wr_en) begin
      img_mem[wr_idx] <= io.Image;
      if (wr_idx < 7'(KerDepth)) begin
        ker1_mem[wr_idx[4:0]] <= io.Kernel_ch1;
        ker2_mem[wr_idx[4:0]] <= io.Kernel_ch2;
      end
      if (!cur_task && (wr_idx < 7'(WbDepth))) wb_mem[wr_idx[5:0]] <= io.Weight_Bias;
      if (cur_task && (wr_idx < 7'(CapDepth))) cap_mem[wr_idx[2:0]] <= io.capacity_cost;
    end
  end

  // Combinational read ports; out-of-range addresses read zero
  always_comb begin
    img_data  = (img_addr < ImgDepth) ? img_mem[img_addr] : '0;
    ker1_data = (ker_addr < KerDepth) ? ker1_mem[ker_addr] : '0;
    ker2_data = (ker_addr < KerDepth) ? ker2_mem[ker_addr] : '0;
    wb_data   = (wb_addr < WbDepth) ? wb_mem[wb_addr] : '0;
    cap_data  = (cap_addr < CapDepth) ? cap_mem[cap_addr] : '0;
  end

  cnn_out_seq u_out_seq (
    .clk         (clk),
    .rst         (rst),
    .wait_res    (state_q == StWaitRes),
    .emit        (state_q == StEmit),
    .n_res       (num_res(frame_task)),
    .res_valid   (io.res_valid),
    .res_data    (io.res_data),
    .res_ready   (io.res_ready),
    .last_accept (last_accept),
    .emit_done   (emit_done),
    .out_valid   (io.out_valid),
    .out         (io.out)
  );

endmodule

// File: tb/tb_cnn_stream_io.sv
// Directed bench for cnn_stream_io: frame capture, result burst, error and reset cases.
module tb_cnn_stream_io;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  img_addr;
  logic [31:0] img_data;
  logic [4:0]  ker_addr;
  logic [31:0] ker1_data, ker2_data;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  cap_addr;
  logic [3:0]  cap_data;
  logic        frame_ready, frame_task, frame_err;
  logic [1:0]  frame_mode;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] caps [5];

  cnn_stream_io_if bus ();

  cnn_stream_io dut (
    .clk         (clk),
    .rst         (rst),
    .io          (bus),
    .img_addr    (img_addr),
    .img_data    (img_data),
    .ker_addr    (ker_addr),
    .ker1_data   (ker1_data),
    .ker2_data   (ker2_data),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .cap_addr    (cap_addr),
    .cap_data    (cap_data),
    .frame_ready (frame_ready),
    .frame_task  (frame_task),
    .frame_mode  (frame_mode),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k: Image=k, Kernel_ch1=100+k, Kernel_ch2=300+k, Weight_Bias=200+k, cap from caps[]
  task automatic send_frame(input logic tsk, input logic [1:0] md, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      bus.in_valid      = 1'b1;
      bus.task_number   = (k == 0) ? tsk : 1'b0;
      bus.mode          = (k == 0) ? md : 2'd0;
      bus.Image         = 32'(k);
      bus.Kernel_ch1    = 32'(100 + k);
      bus.Kernel_ch2    = 32'(300 + k);
      bus.Weight_Bias   = 32'(200 + k);
      bus.capacity_cost = (k < 5) ? caps[k] : 4'd0;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    total_cnt++; if (frame_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", frame_ready); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL rst_err: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if ({frame_task, frame_mode} !== 3'b000) $display("FAIL rst_hdr: got %b want 000", {frame_task, frame_mode}); else pass_cnt++;
    total_cnt++; if (bus.res_ready !== 1'b0) $display("FAIL rst_res_ready: got %b want 0", bus.res_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out !== 32'h0) $display("FAIL rst_out: got %h want 0", bus.out); else pass_cnt++;
  endtask

  task automatic test_cnn_load();
    send_frame(1'b0, 2'd1, 72);
    total_cnt++; if (frame_ready !== 1'b1) $display("FAIL cnn_ready: got %b want 1", frame_ready); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL cnn_err: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if ({frame_task, frame_mode} !== 3'b001) $display("FAIL cnn_hdr: got %b want 001", {frame_task, frame_mode}); else pass_cnt++;
    img_addr = 7'd71; ker_addr = 5'd17; wb_addr = 6'd56; #1;
    total_cnt++; if (img_data !== 32'd71) $display("FAIL img71: got %0d want 71", img_data); else pass_cnt++;
    total_cnt++; if (ker1_data !== 32'd117) $display("FAIL ker1_17: got %0d want 117", ker1_data); else pass_cnt++;
    total_cnt++; if (ker2_data !== 32'd317) $display("FAIL ker2_17: got %0d want 317", ker2_data); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'd256) $display("FAIL wb56: got %0d want 256", wb_data); else pass_cnt++;
    img_addr = 7'd0; #1;
    total_cnt++; if (img_data !== 32'd0) $display("FAIL img0: got %0d want 0", img_data); else pass_cnt++;
    total_cnt++; if (bus.res_ready !== 1'b1) $display("FAIL cnn_res_ready: got %b want 1", bus.res_ready); else pass_cnt++;
  endtask

  task automatic test_cnn_results();
    logic [31:0] vals [3];
    vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000; vals[2] = 32'h4040_0000;
    for (int i = 0; i < 3; i++) begin
      bus.res_valid = 1'b1; bus.res_data = vals[i];
      tick();
      bus.res_valid = 1'b0;
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          total_cnt++; if (bus.out_valid !== 1'b0 || bus.out !== 32'h0) $display("FAIL gap_out: got %b/%h want 0/0", bus.out_valid, bus.out); else pass_cnt++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out !== vals[i]) $display("FAIL emit%0d: got %b/%h want 1/%h", i, bus.out_valid, bus.out, vals[i]); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (bus.res_ready !== 1'b0) $display("FAIL emit_res_ready: got %b want 0", bus.res_ready); else pass_cnt++;
      end
      tick();
    end
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.out !== 32'h0) $display("FAIL post_emit: got %b/%h want 0/0", bus.out_valid, bus.out); else pass_cnt++;
    total_cnt++; if (frame_ready !== 1'b0) $display("FAIL post_emit_ready: got %b want 0", frame_ready); else pass_cnt++;
  endtask

  task automatic test_knap();
    caps[0] = 4'd9; caps[1] = 4'd3; caps[2] = 4'd4; caps[3] = 4'd5; caps[4] = 4'd6;
    send_frame(1'b1, 2'd2, 36);
    total_cnt++; if (frame_ready !== 1'b1) $display("FAIL knap_ready: got %b want 1", frame_ready); else pass_cnt++;
    total_cnt++; if ({frame_task, frame_mode} !== 3'b110) $display("FAIL knap_hdr: got %b want 110", {frame_task, frame_mode}); else pass_cnt++;
    cap_addr = 3'd0; wb_addr = 6'd0; #1;
    total_cnt++; if (cap_data !== 4'd9) $display("FAIL cap0: got %0d want 9", cap_data); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'd200) $display("FAIL wb_persist: got %0d want 200", wb_data); else pass_cnt++;
    cap_addr = 3'd4; #1;
    total_cnt++; if (cap_data !== 4'd6) $display("FAIL cap4: got %0d want 6", cap_data); else pass_cnt++;
    bus.res_valid = 1'b1; bus.res_data = 32'h0000_0015;
    tick();
    bus.res_valid = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out !== 32'h15) $display("FAIL knap_emit: got %b/%h want 1/15", bus.out_valid, bus.out); else pass_cnt++;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.out !== 32'h0) $display("FAIL knap_post: got %b/%h want 0/0", bus.out_valid, bus.out); else pass_cnt++;
  endtask

  // Starts right in the cycle after the last EMIT cycle
  task automatic test_back_to_back();
    caps[0] = 4'd1; caps[1] = 4'd2; caps[2] = 4'd3; caps[3] = 4'd4; caps[4] = 4'd5;
    send_frame(1'b1, 2'd0, 36);
    total_cnt++; if (frame_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", frame_ready); else pass_cnt++;
    cap_addr = 3'd2; #1;
    total_cnt++; if (cap_data !== 4'd3) $display("FAIL b2b_cap2: got %0d want 3", cap_data); else pass_cnt++;
    bus.res_valid = 1'b1; bus.res_data = 32'hABCD_0001;
    tick();
    bus.res_valid = 1'b0;
    total_cnt++; if (bus.out !== 32'hABCD_0001) $display("FAIL b2b_emit: got %h want abcd0001", bus.out); else pass_cnt++;
    tick();
  endtask

  task automatic test_bad_length();
    send_frame(1'b0, 2'd0, 71);
    total_cnt++; if (frame_err !== 1'b1 || frame_ready !== 1'b0) $display("FAIL short_err: got %b/%b want 1/0", frame_err, frame_ready); else pass_cnt++;
    tick();
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL short_pulse: got %b want 0", frame_err); else pass_cnt++;
    send_frame(1'b0, 2'd0, 73);
    total_cnt++; if (frame_err !== 1'b1 || frame_ready !== 1'b0) $display("FAIL long_err: got %b/%b want 1/0", frame_err, frame_ready); else pass_cnt++;
    tick();
    send_frame(1'b0, 2'd3, 72);
    total_cnt++; if (frame_ready !== 1'b1 || frame_err !== 1'b0) $display("FAIL legal_after: got %b/%b want 1/0", frame_ready, frame_err); else pass_cnt++;
  endtask

  // Continues from the legal frame left waiting by test_bad_length
  task automatic test_in_valid_wait();
    bus.in_valid = 1'b1; bus.Image = 32'hDEAD_BEEF;
    tick();
    bus.in_valid = 1'b0;
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL wait_err: got %b want 1", frame_err); else pass_cnt++;
    total_cnt++; if (frame_ready !== 1'b1 || bus.res_ready !== 1'b1) $display("FAIL wait_state: got %b/%b want 1/1", frame_ready, bus.res_ready); else pass_cnt++;
    img_addr = 7'd0; #1;
    total_cnt++; if (img_data !== 32'd0) $display("FAIL wait_ignored: got %h want 0", img_data); else pass_cnt++;
    tick();
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL wait_pulse: got %b want 0", frame_err); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      bus.res_valid = 1'b1; bus.res_data = 32'(11 * (i + 1));
      tick();
      if (i < 2) begin
        total_cnt++; if (bus.out_valid !== 1'b0 || bus.out !== 32'h0) $display("FAIL wait_quiet: got %b/%h want 0/0", bus.out_valid, bus.out); else pass_cnt++;
      end
    end
    bus.res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out !== 32'(11 * (i + 1))) $display("FAIL wait_emit%0d: got %b/%0d want 1/%0d", i, bus.out_valid, bus.out, 11 * (i + 1)); else pass_cnt++;
      tick();
    end
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.out !== 32'h0) $display("FAIL wait_post: got %b/%h want 0/0", bus.out_valid, bus.out); else pass_cnt++;
  endtask

  task automatic test_reset_emit();
    send_frame(1'b0, 2'd0, 72);
    for (int i = 0; i < 3; i++) begin
      bus.res_valid = 1'b1; bus.res_data = 32'(i + 5);
      tick();
    end
    bus.res_valid = 1'b0;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out !== 32'd6) $display("FAIL rst_emit1: got %b/%0d want 1/6", bus.out_valid, bus.out); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.out !== 32'h0) $display("FAIL rst_emit_cut: got %b/%h want 0/0", bus.out_valid, bus.out); else pass_cnt++;
    total_cnt++; if (frame_ready !== 1'b0) $display("FAIL rst_emit_ready: got %b want 0", frame_ready); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (bus.out_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL rst_emit_quiet: got %b/%b want 0/0", bus.out_valid, frame_err); else pass_cnt++;
    end
    total_cnt++; if (bus.res_ready !== 1'b0) $display("FAIL rst_emit_idle: got %b want 0", bus.res_ready); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.task_number = 1'b0; bus.mode = 2'd0;
    bus.Image = '0; bus.Kernel_ch1 = '0; bus.Kernel_ch2 = '0; bus.Weight_Bias = '0;
    bus.capacity_cost = '0; bus.res_valid = 1'b0; bus.res_data = '0;
    img_addr = '0; ker_addr = '0; wb_addr = '0; cap_addr = '0;
    for (int i = 0; i < 5; i++) caps[i] = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_cnn_load();
    test_cnn_results();
    test_knap();
    test_back_to_back();
    test_bad_length();
    test_in_valid_wait();
    test_reset_emit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cnn_stream_io.md
CNN_STREAM_IO -- requirements
Module: cnn_stream_io

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have these input-stream ports: in_valid  in  1  beat strobe; task_number  in  1  0=CNN, 1=knapsack (valid beat 0 only); mode  in  2  mode (valid beat 0 only); Image  in  32  image word; Kernel_ch1/Kernel_ch2  in  32 each  kernel words (beats 0-17); Weight_Bias  in  32  FC weight/bias (beats 0-56, task 0); capacity_cost  in  4  capacity/cost (beats 0-4, task 1).
REQ-003 SHALL have these core read ports (combinational read): img_addr  in  7 / img_data  out  32; ker_addr  in  5 / ker1_data, ker2_data  out  32 each; wb_addr  in  6 / wb_data  out  32; cap_addr  in  3 / cap_data  out  4.
REQ-004 SHALL have these frame-status ports: frame_ready  out  1  buffers complete (level); frame_task  out  1 / frame_mode  out  2  latched header; frame_err  out  1  one-cycle error pulse.
REQ-005 SHALL have these result-handshake ports: res_valid  in  1; res_data  in  32; res_ready  out  1; out_valid  out  1; out  out  32.

Function
REQ-006 SHALL use four states: IDLE, LOAD, WAIT_RES, EMIT.
REQ-007 IDLE, in_valid=1: latch task_number/mode, write beat 0, set beat counter to 1, go to LOAD.
REQ-008 LOAD, in_valid=1: write beat k as Image to img[k]; Kernel_ch1/ch2 to ker[k] if k<18; Weight_Bias to wb[k] if task 0 and k<57; capacity_cost to cap[k] if task 1 and k<5.
REQ-009 Expected frame length SHALL be 72 beats for task 0 and 36 for task 1. Beats beyond the expected length SHALL NOT be written and SHALL set an overrun flag.
REQ-010 LOAD, in_valid falls: if beat count equals expected length and there was no overrun, go to WAIT_RES with frame_ready=1. Otherwise pulse frame_err for one cycle and return to IDLE.
REQ-011 WAIT_RES: res_ready=1 while accepted results < N (N=3 for task 0, N=1 for task 1). Each cycle with res_valid&res_ready SHALL store res_data into rbuf[i]. After the Nth accept, go to EMIT on the next edge.
REQ-012 EMIT: out_valid=1 for exactly N consecutive cycles with out=rbuf[0..N-1] in order. Then out_valid=0, out=0, frame_ready=0, return to IDLE.
REQ-013 The first out_valid cycle SHALL be the cycle after the edge that accepts the Nth result.
REQ-014 out SHALL be 32'h0 whenever out_valid=0. out and out_valid SHALL be registered.
REQ-015 in_valid=1 in WAIT_RES or EMIT: beats SHALL be ignored, frame_err SHALL pulse, and state SHALL be unaffected. out_valid SHALL never rise in a cycle where in_valid=1 is sampled in IDLE/LOAD.
REQ-016 res_valid outside WAIT_RES SHALL be ignored (res_ready=0).
REQ-017 Buffer contents SHALL persist after EMIT until overwritten by the next frame. Unwritten entries SHALL hold their previous values.
REQ-018 A new frame MAY start one cycle after the last EMIT cycle.

Reset
REQ-019 On rst=1 at a rising edge: state=IDLE; counters, overrun flag, frame_ready, frame_task, frame_mode, frame_err, res_ready, out_valid all 0; out=32'h0. Buffers are not required to be cleared.
REQ-020 rst mid-LOAD, mid-WAIT_RES or mid-EMIT SHALL abort the frame. No out_valid and no frame_err SHALL follow.

Structure
REQ-021 Shared package cnn_io_pkg SHALL hold the state enum, the frame lengths (72/36), the stream depths (18/57/5) and the result counts (3/1).
REQ-022 A single sub-module cnn_out_seq SHALL own rbuf, res_ready and the EMIT sequencing. Capture logic SHALL stay in the top.

Verification
REQ-023 Task 0 frame, 72 beats with Image=k, Kernel_ch1=100+k, Weight_Bias=200+k -> frame_ready=1; img_data[71]=71, ker1_data[17]=117, wb_data[56]=256.
REQ-024 Task 1, mode 2, 36 beats with capacity_cost 9,3,4,5,6 -> frame_task=1, frame_mode=2, cap_data[0]=9, cap_data[4]=6. Then one result 32'h0000_0015 -> out_valid for one cycle with out=32'h15.
REQ-025 Task 0 results 3F80_0000, 4000_0000, 4040_0000 fed with 2-cycle gaps -> three consecutive out_valid cycles in that order, the first one cycle after the third accept.
REQ-026 Task 0 frame of 71 beats, then a frame of 73 beats -> frame_err pulse for each, no frame_ready, and a following legal frame completes normally.
REQ-027 in_valid asserted during WAIT_RES -> frame_err pulse; later results are still emitted correctly; out=0 in every cycle with out_valid=0.
REQ-028 rst asserted during the second EMIT cycle -> out_valid=0 and out=0 from the next edge, state IDLE, no further output.
